// File: rtl/seven_seg_scan_pkg.sv
// Shared constants, frame record type and segment table for the seven_seg_scan display driver.
package seven_seg_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Active-low g..a patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        blz;
    } frame_t;

    // True when digit idx and every digit to its left hold zero; digit 0 always shows.
    function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] idx);
        logic zero;
        zero = (idx != 2'd0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && v[k*4 +: 4] != 4'h0) begin
                zero = 1'b0;
            end
        end
        return zero;
    endfunction

endpackage

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module hex_to_seg
    import seven_seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous input capture,
// per-digit enables and leading-zero blanking.
module seven_seg_scan
    import seven_seg_scan_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    logic [1:0] scan_idx;
    logic [1:0] next_idx;
    logic       wrap;
    frame_t     shadow;
    frame_t     live;
    frame_t     view;
    logic [3:0] nibble;
    logic [6:0] seg_raw;
    logic       blanked;
    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    // On the wrap into digit 0 the live inputs are both captured and displayed,
    // so digit 0 never shows a stale frame.
    always_comb begin
        next_idx   = scan_idx + 2'd1;
        wrap       = (scan_idx == 2'd3);
        live.value = value;
        live.dp    = dp_in;
        live.en    = digit_en;
        live.blz   = blank_lz;
        view       = wrap ? live : shadow;
        nibble     = view.value[{next_idx, 2'b00} +: 4];
        blanked    = !view.en[next_idx] || (view.blz && leading_zero(view.value, next_idx));
    end

    hex_to_seg u_hex_to_seg (
        .hex (nibble),
        .seg (seg_raw)
    );

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (!blanked) begin
            an_next  = ~(4'b0001 << next_idx);
            seg_next = seg_raw;
            dp_next  = ~view.dp[next_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_idx <= 2'd3;
            shadow   <= '0;
        end else if (enable) begin
            scan_idx <= next_idx;
            if (wrap) begin
                shadow <= live;
            end
        end
    end

    // frame_start is a pulse, so it drops on idle cycles while the digit drive holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= enable && wrap;
            if (enable) begin
                an  <= an_next;
                seg <= seg_next;
                dp  <= dp_next;
            end
        end
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port list (name  direction  width  meaning):
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  single-cycle scan tick from the upstream clock_enable stage.
- value  input  16  four hex digits; [15:12] is digit 3 (leftmost), [3:0] is digit 0.
- dp_in  input  4  decimal point request per digit; 1 means on.
- digit_en  input  4  per-digit display enable; 0 forces that digit blank.
- blank_lz  input  1  1 enables leading-zero blanking.
- an  output  4  digit anodes, active-low; an[i] drives digit i.
- seg  output  7  segments, active-low; seg[6:0] is g,f,e,d,c,b,a.
- dp  output  1  decimal point, active-low.
- frame_start  output  1  one-cycle pulse when digit 0 is driven at the start of a frame.

Function
REQ-003 The block SHALL hold a 2-bit scan index and advance it only in cycles where enable=1, wrapping 3 to 0.
- enable held high advances the index every cycle.
REQ-004 an, seg, dp and frame_start SHALL be registered outputs.
- They update on the same clock edge that advances the index.
- Their contents correspond to the new index, giving one-cycle latency from enable.
REQ-005 Frame capture: on an enable that moves the index from 3 to 0, the block SHALL load value, dp_in, digit_en and blank_lz into shadow registers.
- The digit 0 outputs in that same update SHALL be decoded from the live inputs, not the old shadow.
REQ-006 For the remaining digits 1 to 3 of the frame, outputs SHALL be decoded from the shadow registers only.
- Input changes mid-frame are not visible until the next frame.
REQ-007 For the selected digit i, an SHALL have exactly bit i low, unless the digit is blanked; a blanked digit drives an=4'b1111, seg=7'h7F and dp=1.
REQ-008 Digit i SHALL be blanked when digit_en[i]=0.
REQ-009 Leading-zero blanking: when blank_lz=1 and nibbles 3 down to i are all zero, digit i SHALL be blanked.
- Digit 0 is never leading-zero blanked.
REQ-010 Hex decode (active-low, g..a), for digit values 0 to F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-011 dp SHALL equal the inverse of the captured dp_in[i] for an unblanked digit.
REQ-012 frame_start SHALL be 1 for exactly the cycle after an enable that moves the index from 3 to 0, and 0 at all other times.
REQ-013 With enable=0, all outputs and all state SHALL hold.

Reset
REQ-014 When reset=1 at a clock edge, the block SHALL set:
- scan index to 3, so the first enable starts a frame;
- an=4'b1111, seg=7'h7F, dp=1, frame_start=0;
- all shadow registers to 0.
REQ-015 Reset SHALL take priority over a simultaneous enable.
REQ-016 Reset mid-frame SHALL abandon that frame; the next enable after reset is deasserted starts a new frame at digit 0.

Structure
REQ-017 A shared package SHALL hold:
- the 16-entry segment encoding table;
- the constants NUM_DIGITS=4, SEG_BLANK=7'h7F and AN_OFF=4'b1111.
REQ-018 The hex-to-segment decode SHALL be a combinational sub-module named hex_to_seg (4-bit in, 7-bit active-low out), instantiated once.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- value=16'h1234, dp_in=0, digit_en=4'hF, blank_lz=0, enable every 4 cycles -> an 1110,1101,1011,0111 with seg 19,30,24,79; frame_start high only with an=1110.
- value=16'h0042, blank_lz=1 -> digits 0,1 show 24 and 19; digits 2,3 slots give an=1111, seg=7F. value=16'h0000 -> only digit 0 shown, seg=40.
- value changes from 16'h1234 to 16'hABCD while digit 1 is displayed -> digits 2,3 still show 2,1; next frame shows D,C,B,A as 21,46,03,08.
- digit_en=4'b1010, dp_in=4'b0010, value=16'h8888 -> digits 0,2 blank; digit 1 gives seg=00, dp=0; digit 3 gives seg=00, dp=1.
- reset asserted with enable=1 during digit 2 -> next cycle an=1111, seg=7F, frame_start=0; first enable after release gives an=1110 and frame_start=1.
- enable held high continuously -> index advances every cycle; frame_start asserts every 4th cycle.
